text_lcd_render: RTL and testbench

TEXT_LCD_RENDER -- requirements
Module: text_lcd_render

---
 rtl/text_lcd_render_pkg.sv | 36 +++
 rtl/text_lcd_render_if.sv | 41 ++++
 rtl/text_lcd_render_char_ram.sv | 37 +++
 rtl/text_lcd_render.sv | 129 ++++++++++++
 tb/tb_text_lcd_render.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/text_lcd_render_pkg.sv
// Shared constants for the text-mode LCD renderer: field widths, default
// geometry, the 16-colour palette and the 512x8 glyph ROM contents.
package text_lcd_pkg;

  localparam int CHAR_W      = 6;
  localparam int ATTR_W      = 8;
  localparam int DATA_W      = CHAR_W + ATTR_W;
  localparam int DEF_H_CHARS = 100;
  localparam int DEF_V_CHARS = 60;

  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  typedef struct packed {
    logic hd;
    logic vd;
    logic den;
  } strobe_t;

  localparam strobe_t STROBE_RST = '{hd: 1'b1, vd: 1'b1, den: 1'b0};

  // Glyph ROM: address {char, row}; char 0 is the blank cell.
  function automatic logic [7:0] rom_char(input logic [8:0] addr);
    logic [5:0] c;
    logic [2:0] r;
    c = addr[8:3];
    r = addr[2:0];
    if (c == 6'd0) return 8'h00;
    return {c[2:0], r, c[5:4]} ^ {5'b10110, r};
  endfunction

endpackage

// File: rtl/text_lcd_render_if.sv
// Pixel-stream and character-buffer write bus of text_lcd_render.
interface text_lcd_render_if
  import text_lcd_pkg::*;
#(
  parameter int H_CHARS = DEF_H_CHARS,
  parameter int V_CHARS = DEF_V_CHARS
);
  localparam int ADDR_W = $clog2(H_CHARS * V_CHARS);

  // No handshake: a pixel is presented every clock, and wr_en qualifies
  // wr_addr/wr_data in the cycle it is high; the renderer never stalls.
  logic [10:0]       Columna;
  logic [9:0]        Fila;
  logic              HD_in;
  logic              VD_in;
  logic              DEN_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cursor_en;
  logic [ADDR_W-1:0] cursor_addr;
  logic              HD;
  logic              VD;
  logic              DEN;
  logic [7:0]        R;
  logic [7:0]        G;
  logic [7:0]        B;

  modport master (
    output Columna, Fila, HD_in, VD_in, DEN_in,
    output wr_en, wr_addr, wr_data, cursor_en, cursor_addr,
    input  HD, VD, DEN, R, G, B
  );

  modport slave (
    input  Columna, Fila, HD_in, VD_in, DEN_in,
    input  wr_en, wr_addr, wr_data, cursor_en, cursor_addr,
    output HD, VD, DEN, R, G, B
  );

endinterface

// File: rtl/text_lcd_render_char_ram.sv
// Simple dual-port character buffer; a read colliding with a write to the
// same cell returns the previous contents. Storage is never reset.
module text_char_ram #(
  parameter int DEPTH  = 6000,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/text_lcd_render.sv
// Three-stage text renderer: buffer read, glyph ROM read, palette select.
// Define TEXT_LCD_CURSOR_EN to build the frame counter and blinking cursor.
module text_lcd_render
  import text_lcd_pkg::*;
#(
  parameter int H_CHARS    = DEF_H_CHARS,
  parameter int V_CHARS    = DEF_V_CHARS,
  parameter int BLINK_LOG2 = 5
) (
  input logic              CLK,
  input logic              RST,
  text_lcd_render_if.slave bus
);

  localparam int DEPTH  = H_CHARS * V_CHARS;
  localparam int ADDR_W = $clog2(DEPTH);

  logic [7:0]        col_cell;
  logic [6:0]        row_cell;
  logic              in_area;
  logic [ADDR_W-1:0] cell_addr;
  logic [DATA_W-1:0] cell_q;
  logic              cursor_hit;

  assign col_cell  = bus.Columna[10:3];
  assign row_cell  = bus.Fila[9:3];
  assign in_area   = (int'(col_cell) < H_CHARS) && (int'(row_cell) < V_CHARS);
  assign cell_addr = ADDR_W'(int'(row_cell) * H_CHARS + int'(col_cell));

  text_char_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_char_ram (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (in_area),
    .rd_addr_i (cell_addr),
    .rd_data_o (cell_q)
  );

`ifdef TEXT_LCD_CURSOR_EN
  logic [BLINK_LOG2:0] frame_q, frame_d;
  logic                vd_prev_q;

  always_comb begin
    frame_d = frame_q;
    if (vd_prev_q && !bus.VD_in) frame_d = frame_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_q   <= '0;
      vd_prev_q <= 1'b1;
    end else begin
      frame_q   <= frame_d;
      vd_prev_q <= bus.VD_in;
    end
  end

  // Cursor occupies the bottom scanline of its cell while the blink phase is high.
  assign cursor_hit = bus.cursor_en && frame_q[BLINK_LOG2] && in_area &&
                      (cell_addr == bus.cursor_addr) && (bus.Fila[2:0] == 3'd7);
`else
  logic unused_cursor;
  assign unused_cursor = ^{bus.cursor_en, bus.cursor_addr, (BLINK_LOG2 > 0)};
  assign cursor_hit    = 1'b0;
`endif

  logic [2:0]  col3_q1, row3_q1;
  logic        area_q1, cur_q1;
  strobe_t     strb_q1;
  logic [2:0]  col3_q2;
  logic [7:0]  attr_q2, glyph_q2;
  logic        area_q2, cur_q2;
  strobe_t     strb_q2, strb_q3;
  logic [23:0] rgb_d, rgb_q;
  logic        pix;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col3_q1  <= '0;
      row3_q1  <= '0;
      area_q1  <= 1'b0;
      cur_q1   <= 1'b0;
      strb_q1  <= STROBE_RST;
      col3_q2  <= '0;
      attr_q2  <= '0;
      glyph_q2 <= '0;
      area_q2  <= 1'b0;
      cur_q2   <= 1'b0;
      strb_q2  <= STROBE_RST;
      strb_q3  <= STROBE_RST;
      rgb_q    <= '0;
    end else begin
      col3_q1  <= bus.Columna[2:0];
      row3_q1  <= bus.Fila[2:0];
      area_q1  <= in_area;
      cur_q1   <= cursor_hit;
      strb_q1  <= '{hd: bus.HD_in, vd: bus.VD_in, den: bus.DEN_in};
      col3_q2  <= col3_q1;
      attr_q2  <= cell_q[DATA_W-1:CHAR_W];
      glyph_q2 <= rom_char({cell_q[CHAR_W-1:0], row3_q1});
      area_q2  <= area_q1;
      cur_q2   <= cur_q1;
      strb_q2  <= strb_q1;
      strb_q3  <= strb_q2;
      rgb_q    <= rgb_d;
    end
  end

  // Glyph bit 0 is the leftmost pixel of the cell.
  always_comb begin
    rgb_d = '0;
    pix   = cur_q2 | glyph_q2[col3_q2];
    if (strb_q2.den) begin
      if (!area_q2)  rgb_d = PALETTE[0];
      else if (pix)  rgb_d = PALETTE[attr_q2[7:4]];
      else           rgb_d = PALETTE[attr_q2[3:0]];
    end
  end

  assign bus.R   = rgb_q[23:16];
  assign bus.G   = rgb_q[15:8];
  assign bus.B   = rgb_q[7:0];
  assign bus.HD  = strb_q3.hd;
  assign bus.VD  = strb_q3.vd;
  assign bus.DEN = strb_q3.den;

endmodule

// File: tb/tb_text_lcd_render.sv
// Self-checking bench for text_lcd_render: directed and random pixel scans
// compared against a cell/glyph/palette reference model.
module tb_text_lcd_render;

  localparam int H     = 100;
  localparam int V     = 60;
  localparam int DEPTH = H * V;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [23:0] PAL [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };
  localparam logic [26:0] RST_OUT = {1'b1, 1'b1, 1'b0, 24'h0};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  text_lcd_render_if #(.H_CHARS(H), .V_CHARS(V)) bus ();

  text_lcd_render #(.H_CHARS(H), .V_CHARS(V), .BLINK_LOG2(5)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // scoreboard state
  logic [26:0] exp_q[$];
  int          model_mem [DEPTH];
  int          frames;
  logic        prev_vd;
  logic        cur_en;
  int          cur_addr;
  int          errors;
  int          checks;
  int          n_pix;
  string       phase;

  task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int glyph(input int ch, input int r);
    if (ch == 0) return 0;
    return ((ch % 8) * 32 + r * 4 + ch / 16) ^ (176 + r);
  endfunction

  function automatic logic [26:0] model_pixel(input int col, input int row,
                                              input logic hd, input logic vd, input logic den);
    logic [23:0] rgb;
    int cc, rr, w, on;
    rgb = 24'h0;
    if (den) begin
      cc = col / 8;
      rr = row / 8;
      if (cc >= H || rr >= V) begin
        rgb = PAL[0];
      end else begin
        w  = model_mem[rr * H + cc];
        on = (glyph(w % 64, row % 8) >> (col % 8)) & 1;
`ifdef TEXT_LCD_CURSOR_EN
        if (cur_en && (frames % 64) >= 32 && cur_addr == rr * H + cc && row % 8 == 7) on = 1;
`endif
        rgb = (on != 0) ? PAL[(w / 1024) % 16] : PAL[(w / 64) % 16];
      end
    end
    return {hd, vd, den, rgb};
  endfunction

  // driver: one pixel (and optional write) per clock, checked 3 clocks later
  task automatic step(input int col, input int row, input logic hd, input logic vd,
                      input logic den, input logic we, input int waddr, input int wdata);
    logic [26:0] e;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check($sformatf("%s_%0d", phase, n_pix), {bus.HD, bus.VD, bus.DEN, bus.R, bus.G, bus.B}, e);
    end
    n_pix++;
    bus.Columna     = 11'(col);
    bus.Fila        = 10'(row);
    bus.HD_in       = hd;
    bus.VD_in       = vd;
    bus.DEN_in      = den;
    bus.wr_en       = we;
    bus.wr_addr     = AW'(waddr);
    bus.wr_data     = 14'(wdata);
    bus.cursor_en   = cur_en;
    bus.cursor_addr = AW'(cur_addr);
    exp_q.push_back(model_pixel(col, row, hd, vd, den));
    if (we && waddr < DEPTH) model_mem[waddr] = wdata;
    if (prev_vd && !vd) frames++;
    prev_vd = vd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart_model();
    exp_q.delete();
    repeat (3) exp_q.push_back(RST_OUT);
    frames  = 0;
    prev_vd = 1'b1;
  endtask

  task automatic pixel(input int col, input int row);
    step(col, row, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    errors = 0; checks = 0; n_pix = 0;
    cur_en = 1'b1; cur_addr = 0;
    bus.Columna = '0; bus.Fila = '0; bus.HD_in = 1'b1; bus.VD_in = 1'b1; bus.DEN_in = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.cursor_en = 1'b1; bus.cursor_addr = '0;

    // reset values
    repeat (2) @(negedge clk);
    check("reset", {bus.HD, bus.VD, bus.DEN, bus.R, bus.G, bus.B}, RST_OUT);
    rst = 1'b0;
    restart_model();

    // preload every cell while blanked
    phase = "preload";
    for (int a = 0; a < DEPTH; a++)
      step($urandom_range(0, 799), $urandom_range(0, 479), 1'b1, 1'b1, 1'b0, 1'b1, a,
           int'($urandom_range(0, 16383)));

    // char 6'o12, fg 15 / bg 0 at cell 0, scanned across its top row
    phase = "cell0";
    step(500, 300, 1'b1, 1'b1, 1'b1, 1'b1, 0, (8'hF0 << 6) | 6'o12);
    for (int x = 0; x < 8; x++) pixel(x, 0);

    // a blanked line with toggling strobes
    phase = "blank";
    for (int x = 0; x < 200; x++)
      step(x, 8, 1'(x < 20 || x > 190), 1'(x % 50 != 7), 1'b0, 1'b0, 0, 0);

    // out-of-range write ignored, out-of-area pixels render palette[0]
    phase = "range";
    step(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, DEPTH, 16383);
    pixel(800, 0);
    pixel(807, 17);
    pixel(3, 480);
    for (int x = 0; x < 8; x++) pixel(x, 0);

    // same-cycle write/read of cell 5 renders old data, then new
    phase = "collide";
    step(0, 9, 1'b1, 1'b1, 1'b1, 1'b1, 5, (2 << 10) | (3 << 6) | 1);
    step(40, 0, 1'b1, 1'b1, 1'b1, 1'b1, 5, (4 << 10) | (5 << 6) | 2);
    pixel(41, 0);
    pixel(40, 0);

`ifdef TEXT_LCD_CURSOR_EN
    // blank cell 0 with distinct fg/bg, then sample both blink phases
    phase = "cursor";
    cur_addr = 0;
    step(8, 8, 1'b1, 1'b1, 1'b1, 1'b1, 0, (14 << 10) | (1 << 6));
    while ((frames % 64) != 5) begin
      step(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    for (int x = 0; x < 8; x++) begin pixel(x, 7); pixel(x, 6); end
    while ((frames % 64) != 40) begin
      step(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    for (int x = 0; x < 8; x++) begin pixel(x, 7); pixel(x, 6); end
`endif

    // random scan with concurrent writes
    phase = "random";
    for (int i = 0; i < 2000; i++) begin
      cur_addr = $urandom_range(0, 7);
      step($urandom_range(0, 850), $urandom_range(0, 500), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           $urandom_range(0, DEPTH + 100), int'($urandom_range(0, 16383)));
    end

    // asynchronous reset in the middle of a visible line
    phase = "midline";
    for (int x = 0; x < 16; x++) pixel(x, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.VD_in = 1'b1;
    #1;
    check("rst_async", {bus.HD, bus.VD, bus.DEN, bus.R, bus.G, bus.B}, RST_OUT);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    restart_model();
    phase = "post_rst";
    for (int x = 0; x < 24; x++) pixel(x, x % 16);

    // drain
    phase = "drain";
    repeat (3) step(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
